// File: rtl/detect_count_display.sv
// Counts rising edges of the sequence detector's output in a 4-digit BCD counter
// and scans the count onto a common-anode, active-low 4-digit seven-segment display.
module detect_count_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        det_in,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    logic          det_q;
    logic          inc;
    logic [15:0]   count_nxt;
    logic          wrap;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    dig_sel;
    logic [3:0]    nibble;

    assign inc = det_in & ~det_q;

    // Ripple carry through all four digits within one cycle; wrap means every digit was 9.
    always_comb begin
        logic carry;
        count_nxt = count_bcd;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_bcd[4*i +: 4] >= 4'd9) begin
                    count_nxt[4*i +: 4] = 4'd0;
                end else begin
                    count_nxt[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    // det_q resets high so a level already asserted at reset release is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q     <= 1'b1;
            count_bcd <= 16'h0000;
            ovf       <= 1'b0;
        end else begin
            det_q <= det_in;
            if (clr) begin
                count_bcd <= 16'h0000;
                ovf       <= 1'b0;
            end else if (inc) begin
                count_bcd <= count_nxt;
                if (wrap) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            dig_sel     <= 2'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            dig_sel     <= dig_sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    always_comb begin
        case (dig_sel)
            2'd0:    nibble = count_bcd[3:0];
            2'd1:    nibble = count_bcd[7:4];
            2'd2:    nibble = count_bcd[11:8];
            default: nibble = count_bcd[15:12];
        endcase
    end

    always_comb begin
        an = ~(4'b0001 << dig_sel);
    end

    always_comb begin
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_detect_count_display.sv
// Scoreboard bench for detect_count_display: a driver pushes expected count/ovf per cycle,
// a monitor pops and checks them along with the multiplexed display on two refresh rates.
module tb_detect_count_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        det_in = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] count4, count1;
    logic        ovf4, ovf1;
    logic [3:0]  an4, an1;
    logic [6:0]  seg4, seg1;

    detect_count_display #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
        .count_bcd(count4), .ovf(ovf4), .an(an4), .seg(seg4)
    );

    detect_count_display #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
        .count_bcd(count1), .ovf(ovf1), .an(an1), .seg(seg1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        m_prev = 1'b1;
    int          n = 0;
    logic [15:0] cur_cnt = 16'h0000;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic logic [15:0] to_bcd(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d < 4'd10) ? segtab[d] : 7'b1111111;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One driven cycle: apply inputs after the edge, advance the reference model, queue the result.
    task automatic step(input logic d, input logic c);
        logic inc;
        exp_t e;
        @(posedge clk);
        #2;
        det_in = d;
        clr    = c;
        inc    = d && !m_prev;
        m_prev = d;
        if (c) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (inc) begin
            m_cnt++;
            if (m_cnt == 10000) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
        end
        e.cnt = to_bcd(m_cnt);
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    task automatic pulses(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    // Checks the state produced by the previously issued step against a spec-derived constant.
    task automatic ms(input string nm, input logic [15:0] c, input logic o);
        step(1'b0, 1'b0);
        chk({nm, "_count"}, {16'h0, count4}, {16'h0, c});
        chk({nm, "_ovf"}, {31'h0, ovf4}, {31'h0, o});
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_count"}, {16'h0, count4}, 32'h0);
        chk({nm, "_ovf"}, {31'h0, ovf4}, 32'h0);
        chk({nm, "_an"}, {28'h0, an4}, 32'he);
        chk({nm, "_seg"}, {25'h0, seg4}, 32'h40);
        chk({nm, "_an1"}, {28'h0, an1}, 32'he);
    endtask

    // Monitor: one sample per clock, just after the active edge.
    initial begin
        exp_t        e;
        int          s4, s1;
        logic [3:0]  ea;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                n++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("count_div4", {16'h0, count4}, {16'h0, e.cnt});
                    chk("ovf_div4", {31'h0, ovf4}, {31'h0, e.ovf});
                    chk("count_div1", {16'h0, count1}, {16'h0, e.cnt});
                    chk("ovf_div1", {31'h0, ovf1}, {31'h0, e.ovf});
                    cur_cnt = e.cnt;
                end
                s4 = (n / 4) % 4;
                s1 = n % 4;
                ea = ~(4'b0001 << s4);
                chk("an_div4", {28'h0, an4}, {28'h0, ea});
                chk("seg_div4", {25'h0, seg4}, {25'h0, seg_of(cur_cnt[4*s4 +: 4])});
                ea = ~(4'b0001 << s1);
                chk("an_div1", {28'h0, an1}, {28'h0, ea});
                chk("seg_div1", {25'h0, seg1}, {25'h0, seg_of(cur_cnt[4*s1 +: 4])});
            end
        end
    end

    initial begin
        #3;
        chk_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_prev = 1'b1;

        // Level high across reset release is not counted.
        repeat (5) step(1'b1, 1'b0);
        ms("held_at_release", 16'h0000, 1'b0);
        step(1'b1, 1'b0);
        ms("first_edge", 16'h0001, 1'b0);

        step(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        ms("twelve", 16'h0012, 1'b0);
        repeat (50) step(1'b1, 1'b0);
        ms("held_high", 16'h0013, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Multiplex pattern at 1234, observed over several full scans.
        step(1'b0, 1'b1);
        pulses(1234);
        ms("mux_value", 16'h1234, 1'b0);
        repeat (40) step(1'b0, 1'b0);

        step(1'b0, 1'b1);
        pulses(9999);
        ms("pre_wrap", 16'h9999, 1'b0);
        step(1'b1, 1'b0);
        ms("wrap", 16'h0000, 1'b1);
        step(1'b1, 1'b0);
        ms("after_wrap", 16'h0001, 1'b1);
        step(1'b0, 1'b1);
        ms("clr_ovf", 16'h0000, 1'b0);

        pulses(457);
        ms("at_457", 16'h0457, 1'b0);
        step(1'b1, 1'b1);
        ms("clr_beats_inc", 16'h0000, 1'b0);
        step(1'b1, 1'b0);
        ms("after_dropped", 16'h0001, 1'b0);

        // Mid-run reset with det_in high aborts immediately.
        pulses(37);
        step(1'b1, 1'b0);
        #1;
        rst = 1'b1;
        q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_prev  = 1'b1;
        n       = 0;
        cur_cnt = 16'h0000;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) step(1'b1, 1'b0);
        ms("reset_release_high", 16'h0000, 1'b0);
        step(1'b1, 1'b0);
        ms("reset_then_edge", 16'h0001, 1'b0);

        step(1'b0, 1'b1);
        pulses(100);
        ms("rate_limit", 16'h0100, 1'b0);

        repeat (3) step(1'b0, 1'b0);
        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detect_count_display.md
# detect_count_display

Downstream consumer of the 1101 sequence detector's registered `detected` output. Counts rising edges of the detect signal in a 4-digit BCD counter (0000–9999, wrapping) and drives a time-multiplexed, common-anode 4-digit seven-segment display with the count. It runs in the detector's `clk` domain, so no synchronizer is needed on `det_in`.

## Interface
- `REFRESH_DIV`, default 100000: `clk` cycles per displayed digit. 100000 gives 1 kHz per digit at 100 MHz. Legal range ≥ 1.
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `det_in`  in  1  detect pulse/level from the sequence detector, same clock domain
- `clr`  in  1  synchronous clear of count and overflow flag, active-high
- `count_bcd`  out  16  registered count; `[15:12]` thousands, `[11:8]` hundreds, `[7:4]` tens, `[3:0]` ones
- `ovf`  out  1  sticky flag, set on the 9999→0000 wrap
- `an`  out  4  digit anodes, active-low one-hot; `an[0]` = ones digit
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g

## Operation
- **Edge detect**
  - `det_q` register holds the previous `det_in`.
  - `inc = det_in & ~det_q`.
  - `det_q` resets to 1, so a level already high at reset release is not counted.
  - A level held high counts once.
  - Back-to-back pulses separated by at least one low cycle count separately.
- **BCD counter**
  - On `inc`: ones digit +1. A digit at 9 goes to 0 and carries into the next digit.
  - No digit ever holds a value above 9.
  - 9999 + `inc` → 0000 and sets `ovf`. `ovf` stays set until `clr` or `rst`.
- **Clear**
  - `clr` sets `count_bcd` = 0 and `ovf` = 0 on the next edge.
  - `clr` has priority over a simultaneous `inc`; that event is dropped.
  - `det_q` still updates during `clr`.
- **Refresh**
  - `refresh_cnt` counts 0 … `REFRESH_DIV`−1.
  - At terminal count it returns to 0 and the 2-bit `dig_sel` increments 0→1→2→3→0.
  - Refresh is free-running and unaffected by `clr`.
- **Outputs**
  - `an` = ~(1 << `dig_sel`): 1110, 1101, 1011, 0111 for digits 0–3.
  - `seg` is a combinational decode of the selected nibble, all active-low as 7-bit `gfedcba`:
    - 0 = 1000000
    - 1 = 1111001
    - 2 = 0100100
    - 3 = 0110000
    - 4 = 0011001
    - 5 = 0010010
    - 6 = 0000010
    - 7 = 1111000
    - 8 = 0000000
    - 9 = 0010000
    - Any other value = 1111111 (blank; unreachable).
  - No leading-zero blanking.
- **Reset values**
  - `count_bcd` = 0x0000, `ovf` = 0, `det_q` = 1, `refresh_cnt` = 0, `dig_sel` = 0.
  - Therefore `an` = 1110 and `seg` = 1000000.
  - Reset mid-count aborts immediately; no partial carry survives.

## Timing
- Latency:
  - `det_in` first sampled high at edge k (previous sample low) → `count_bcd` shows the new value after edge k.
  - `ovf` sets at the same edge k as the wrap.
  - `clr` sampled at edge k → `count_bcd` = 0 after edge k.
- Maximum count rate is one per 2 cycles, because a low cycle is required between pulses. The upstream detector cannot produce consecutive-cycle detects, so no event is lost.
- `dig_sel` advances after every `REFRESH_DIV` edges.
  - `REFRESH_DIV` = 1: advances every edge.
  - Full display scan = 4·`REFRESH_DIV` cycles.
- `an` and `seg` change in the same cycle as `dig_sel` or `count_bcd`, with no extra register stage.
- The full ripple carry 9999→0000 completes in one cycle. All four digits update on the same edge.

## Test plan
- **Reset:** assert `rst` mid-simulation with `det_in`=1 → outputs immediately `count_bcd`=0x0000, `ovf`=0, `an`=1110, `seg`=1000000. Release with `det_in` held high → count stays 0000 until `det_in` goes low then high → 0001.
- **Counting:** 12 single-cycle `det_in` pulses spaced 3 cycles apart → `count_bcd`=0x0012. Hold `det_in` high 50 cycles → count increments exactly once → 0x0013.
- **Carry/wrap:** drive 9999 pulses → 0x9999, `ovf`=0. One more pulse → 0x0000 and `ovf`=1 at that edge. A further pulse → 0x0001 with `ovf` still 1. `clr` → 0x0000, `ovf`=0.
- **Simultaneous:** `clr`=1 in the same cycle as a `det_in` rising edge, count at 0x0457 → 0x0000. The next rising edge after `clr` drops → 0x0001.
- **Multiplex:** `REFRESH_DIV`=4, count 0x1234 → `an` sequence 1110, 1101, 1011, 0111, each held 4 cycles, with `seg` 0011001, 0110000, 0100100, 1111001 respectively. The sequence repeats every 16 cycles.
- **Boundary:** `REFRESH_DIV`=1 → `dig_sel` changes every cycle. Pulse every 2nd cycle for 200 cycles → count 0x0100, no lost events.
